// File: rtl/instruction_fetch_stage.sv
// RV32I IF stage: PC register, instruction-memory request handshake, redirect/stall handling
// and the IF/ID pipeline register feeding decode.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchWaitF
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc_f;
    logic [31:0] redir_pc;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;

    logic [31:0] pc_plus4_f;
    logic [31:0] target_f;
    logic [31:0] instr_f;
    logic [31:0] instr_pc_f;
    logic        have_instr;
    logic        advance;

    assign pc_plus4_f = pc_f + 32'd4;
    assign target_f   = {PCTargetE[31:2], 2'b00};

    // A usable word comes either straight from memory (FETCH) or from the hold buffer (HOLD);
    // responses seen in DROP belong to a squashed path and are never usable.
    assign have_instr = (state == HOLD) || ((state == FETCH) && imem_valid);
    assign instr_f    = (state == HOLD) ? hold_instr : imem_rdata;
    assign instr_pc_f = (state == HOLD) ? hold_pc : pc_f;
    assign advance    = have_instr && !StallF && !PCSrcE;

    assign imem_req   = rst && (state != HOLD);
    assign imem_addr  = pc_f;
    assign FetchWaitF = imem_req && !imem_valid;

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FETCH;
            pc_f       <= RESET_PC;
            redir_pc   <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (PCSrcE) begin
            case (state)
                FETCH: begin
                    if (imem_valid) begin
                        pc_f <= target_f;
                    end else begin
                        // Request already on the bus must complete; park the target until it does.
                        redir_pc <= target_f;
                        state    <= DROP;
                    end
                end
                DROP:    redir_pc <= target_f;
                default: begin
                    pc_f  <= target_f;
                    state <= FETCH;
                end
            endcase
        end else if (StallF) begin
            if ((state == FETCH) && imem_valid) begin
                hold_instr <= imem_rdata;
                hold_pc    <= pc_f;
                state      <= HOLD;
            end
        end else if (advance) begin
            pc_f  <= pc_plus4_f;
            state <= FETCH;
        end else if ((state == DROP) && imem_valid) begin
            pc_f  <= redir_pc;
            state <= FETCH;
        end else if ((state != FETCH) && (state != HOLD) && (state != DROP)) begin
            state <= FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD || PCSrcE) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (advance) begin
                InstrD   <= instr_f;
                PCD      <= instr_pc_f;
                PCPlus4D <= instr_pc_f + 32'd4;
                ValidD   <= 1'b1;
            end else begin
                InstrD   <= NOP_INSTR;
                PCD      <= '0;
                PCPlus4D <= '0;
                ValidD   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed scenarios plus a randomized run
// checked against a program-order stream model and a memory-protocol model.
module tb_instruction_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, FetchWaitF;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned wait_cfg  = 0;
    bit          rand_wait = 0;
    int unsigned wait_left = 0;

    instruction_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .FetchWaitF(FetchWaitF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0 || a == 32'h4) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A00_0013;
    endfunction

    function automatic int unsigned pick_wait();
        if (rand_wait) return $urandom_range(0, 3);
        return wait_cfg;
    endfunction

    // Instruction memory: a configurable number of wait cycles per request, aborted by reset.
    assign imem_valid = imem_req && (wait_left == 0);
    assign imem_rdata = imem_valid ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (!rst)                        wait_left <= pick_wait();
        else if (imem_req && imem_valid) wait_left <= pick_wait();
        else if (imem_req)               wait_left <= wait_left - 1;
    end

    always @(posedge clk) begin
        if (rst) assert (!(StallD && !StallF)) else $error("illegal StallD without StallF");
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
        repeat (2) tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
        wait_cfg = 0; rand_wait = 0;
        repeat (3) tick();
        n_cmp++;
        if (InstrD !== NOP_INSTR || ValidD !== 1'b0 || PCD !== 32'h0 || PCPlus4D !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_decode: got InstrD=%h ValidD=%b PCD=%h PCPlus4D=%h, required %h/0/0/0",
                     InstrD, ValidD, PCD, PCPlus4D, NOP_INSTR);
        end
        n_cmp++;
        if (imem_req !== 1'b0 || FetchWaitF !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_req: got imem_req=%b FetchWaitF=%b, required 0/0", imem_req, FetchWaitF);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            n_bad++;
            $display("FAIL reset_first_req: got req=%b addr=%h, required 1/%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_zero_wait();
        wait_cfg = 0; rand_wait = 0;
        do_reset();
        n_cmp++;
        if (imem_addr !== 32'h0) begin
            n_bad++; $display("FAIL zw_addr0: got %h, required 0", imem_addr);
        end
        tick();
        n_cmp++;
        if (InstrD !== 32'h0050_0093 || PCD !== 32'h0 || PCPlus4D !== 32'h4 || ValidD !== 1'b1) begin
            n_bad++;
            $display("FAIL zw_first: got InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b, required 00500093/0/4/1",
                     InstrD, PCD, PCPlus4D, ValidD);
        end
        n_cmp++;
        if (imem_addr !== 32'h4) begin
            n_bad++; $display("FAIL zw_addr4: got %h, required 4", imem_addr);
        end
        tick();
        n_cmp++;
        if (imem_addr !== 32'h8 || PCD !== 32'h4 || InstrD !== 32'h0050_0093) begin
            n_bad++;
            $display("FAIL zw_second: got addr=%h PCD=%h InstrD=%h, required 8/4/00500093", imem_addr, PCD, InstrD);
        end
    endtask

    task automatic test_wait_states();
        wait_cfg = 2; rand_wait = 0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || FetchWaitF !== 1'b1 ||
                ValidD !== 1'b0 || InstrD !== NOP_INSTR) begin
                n_bad++;
                $display("FAIL ws_wait%0d: got req=%b addr=%h FetchWaitF=%b ValidD=%b InstrD=%h, required 1/0/1/0/%h",
                         i, imem_req, imem_addr, FetchWaitF, ValidD, InstrD, NOP_INSTR);
            end
            tick();
        end
        n_cmp++;
        if (FetchWaitF !== 1'b0 || imem_addr !== 32'h0) begin
            n_bad++; $display("FAIL ws_resp: got FetchWaitF=%b addr=%h, required 0/0", FetchWaitF, imem_addr);
        end
        wait_cfg = 0;
        tick();
        n_cmp++;
        if (InstrD !== 32'h0050_0093 || PCD !== 32'h0 || ValidD !== 1'b1) begin
            n_bad++;
            $display("FAIL ws_instr: got InstrD=%h PCD=%h ValidD=%b, required 00500093/0/1", InstrD, PCD, ValidD);
        end
    endtask

    task automatic test_stall_hold();
        wait_cfg = 0; rand_wait = 0;
        do_reset();
        repeat (2) tick();
        n_cmp++;
        if (imem_addr !== 32'h8 || imem_valid !== 1'b1) begin
            n_bad++; $display("FAIL sh_addr8: got addr=%h valid=%b, required 8/1", imem_addr, imem_valid);
        end
        StallF = 1; StallD = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (imem_req !== 1'b0 || PCD !== 32'h4 || ValidD !== 1'b1) begin
                n_bad++;
                $display("FAIL sh_hold%0d: got req=%b PCD=%h ValidD=%b, required 0/4/1", i, imem_req, PCD, ValidD);
            end
        end
        StallF = 0; StallD = 0;
        tick();
        n_cmp++;
        if (PCD !== 32'h8 || InstrD !== mem_word(32'h8) || ValidD !== 1'b1 || imem_addr !== 32'hC) begin
            n_bad++;
            $display("FAIL sh_release: got PCD=%h InstrD=%h ValidD=%b addr=%h, required 8/%h/1/c",
                     PCD, InstrD, ValidD, imem_addr, mem_word(32'h8));
        end
    endtask

    task automatic test_redirect_drop();
        bit seen;
        wait_cfg = 0; rand_wait = 0;
        do_reset();
        repeat (3) tick();
        wait_cfg = 3;
        tick();
        n_cmp++;
        if (imem_addr !== 32'h10 || PCD !== 32'hC) begin
            n_bad++; $display("FAIL rd_setup: got addr=%h PCD=%h, required 10/c", imem_addr, PCD);
        end
        PCSrcE = 1; PCTargetE = 32'h0000_0103;
        tick();
        PCSrcE = 0; PCTargetE = '0;
        #1;
        n_cmp++;
        if (ValidD !== 1'b0 || InstrD !== NOP_INSTR || imem_req !== 1'b1 || FetchWaitF !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_bubble: got ValidD=%b InstrD=%h req=%b FetchWaitF=%b, required 0/%h/1/1",
                     ValidD, InstrD, imem_req, FetchWaitF, NOP_INSTR);
        end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            n_cmp++;
            if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin
                n_bad++; $display("FAIL rd_stale_addr: got req=%b addr=%h, required 1/10", imem_req, imem_addr);
            end
            if (imem_valid) seen = 1;
            else tick();
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL rd_timeout: got no response in 10 cycles, required one");
        end
        wait_cfg = 0;
        tick();
        n_cmp++;
        if (imem_addr !== 32'h100 || ValidD !== 1'b0) begin
            n_bad++; $display("FAIL rd_target: got addr=%h ValidD=%b, required 100/0", imem_addr, ValidD);
        end
        tick();
        n_cmp++;
        if (PCD !== 32'h100 || InstrD !== mem_word(32'h100) || ValidD !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_first: got PCD=%h InstrD=%h ValidD=%b, required 100/%h/1", PCD, InstrD, ValidD, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_on_valid();
        wait_cfg = 0; rand_wait = 0;
        do_reset();
        repeat (5) tick();
        n_cmp++;
        if (imem_addr !== 32'h14 || imem_valid !== 1'b1) begin
            n_bad++; $display("FAIL rv_setup: got addr=%h valid=%b, required 14/1", imem_addr, imem_valid);
        end
        PCSrcE = 1; PCTargetE = 32'h40;
        tick();
        PCSrcE = 0; PCTargetE = '0;
        #1;
        n_cmp++;
        if (imem_addr !== 32'h40 || ValidD !== 1'b0 || InstrD !== NOP_INSTR) begin
            n_bad++;
            $display("FAIL rv_redirect: got addr=%h ValidD=%b InstrD=%h, required 40/0/%h", imem_addr, ValidD, InstrD, NOP_INSTR);
        end
        tick();
        n_cmp++;
        if (PCD !== 32'h40 || InstrD !== mem_word(32'h40) || ValidD !== 1'b1) begin
            n_bad++;
            $display("FAIL rv_first: got PCD=%h InstrD=%h ValidD=%b, required 40/%h/1", PCD, InstrD, ValidD, mem_word(32'h40));
        end
    endtask

    task automatic test_wrap_and_reset();
        wait_cfg = 0; rand_wait = 0;
        do_reset();
        PCSrcE = 1; PCTargetE = 32'hFFFF_FFFC;
        tick();
        PCSrcE = 0; PCTargetE = '0;
        wait_cfg = 3;
        #1;
        n_cmp++;
        if (imem_addr !== 32'hFFFF_FFFC || imem_valid !== 1'b1) begin
            n_bad++; $display("FAIL wr_addr: got addr=%h valid=%b, required fffffffc/1", imem_addr, imem_valid);
        end
        tick();
        n_cmp++;
        if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || ValidD !== 1'b1 || imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL wr_wrap: got PCD=%h PCPlus4D=%h ValidD=%b addr=%h, required fffffffc/0/1/0",
                     PCD, PCPlus4D, ValidD, imem_addr);
        end
        n_cmp++;
        if (FetchWaitF !== 1'b1) begin
            n_bad++; $display("FAIL wr_waiting: got FetchWaitF=%b, required 1", FetchWaitF);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || FetchWaitF !== 1'b0) begin
            n_bad++; $display("FAIL mr_req_low: got req=%b FetchWaitF=%b, required 0/0", imem_req, FetchWaitF);
        end
        wait_cfg = 0;
        tick();
        n_cmp++;
        if (ValidD !== 1'b0 || InstrD !== NOP_INSTR || imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
            n_bad++;
            $display("FAIL mr_state: got ValidD=%b InstrD=%h req=%b PCF=%h, required 0/%h/0/%h",
                     ValidD, InstrD, imem_req, imem_addr, NOP_INSTR, RESET_PC);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            n_bad++; $display("FAIL mr_restart: got req=%b addr=%h, required 1/%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    // Stream model: every instruction entering decode must be the next one in program order,
    // where program order restarts at the aligned target of each redirect.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        bit          prev_stalld;
        bit          prev_pending;
        int          loads;
        int          stream_errs;
        int          pend_cycles;
        rand_wait = 1;
        do_reset();
        exp_pc = RESET_PC; prev_stalld = 0; prev_pending = 0; prev_addr = '0;
        loads = 0; stream_errs = 0; pend_cycles = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (ValidD === 1'b1 && !prev_stalld) begin
                n_cmp++;
                if (PCD !== exp_pc || InstrD !== mem_word(exp_pc) || PCPlus4D !== exp_pc + 32'd4) begin
                    n_bad++;
                    stream_errs++;
                    if (stream_errs <= 5)
                        $display("FAIL rnd_stream cyc %0d: got PCD=%h InstrD=%h PCPlus4D=%h, required %h/%h/%h",
                                 cyc, PCD, InstrD, PCPlus4D, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
                loads++;
            end else if (ValidD === 1'b0) begin
                n_cmp++;
                if (InstrD !== NOP_INSTR) begin
                    n_bad++; $display("FAIL rnd_bubble cyc %0d: got InstrD=%h, required %h", cyc, InstrD, NOP_INSTR);
                end
            end
            n_cmp++;
            if (FetchWaitF !== (imem_req && !imem_valid)) begin
                n_bad++;
                $display("FAIL rnd_fetchwait cyc %0d: got %b, required %b", cyc, FetchWaitF, imem_req && !imem_valid);
            end
            if (prev_pending) begin
                n_cmp++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    n_bad++;
                    $display("FAIL rnd_req_stable cyc %0d: got req=%b addr=%h, required 1/%h", cyc, imem_req, imem_addr, prev_addr);
                end
            end
            pend_cycles = (imem_req && !imem_valid) ? pend_cycles + 1 : 0;
            if (pend_cycles == 20) begin
                n_cmp++; n_bad++;
                $display("FAIL rnd_stuck cyc %0d: got request pending 20 cycles, required response within 4", cyc);
            end

            StallF    = ($urandom_range(0, 3) == 0);
            StallD    = StallF && ($urandom_range(0, 1) == 1);
            PCSrcE    = ($urandom_range(0, 15) == 0);
            PCTargetE = $urandom;
            FlushD    = PCSrcE || (StallF && ($urandom_range(0, 3) == 0));
            if (PCSrcE) exp_pc = {PCTargetE[31:2], 2'b00};
            #1;
            prev_stalld  = StallD;
            prev_pending = imem_req && !imem_valid;
            prev_addr    = imem_addr;
            tick();
        end
        StallF = 0; StallD = 0; PCSrcE = 0; FlushD = 0;
        n_cmp++;
        if (loads < 200) begin
            n_bad++; $display("FAIL rnd_throughput: got %0d instructions, required at least 200", loads);
        end
    endtask

    initial begin
        rst = 1'b0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_redirect_drop();
        test_redirect_on_valid();
        test_wrap_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
